// File: rtl/axis_width_conv_gearbox_if.sv
// Stream handshake bundle used on both sides of the gearbox.
// The producer drives data, flags and valid; the consumer drives tnext.
interface axis_width_conv_gearbox_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tdata;
  logic             tfirst;
  logic             tlast;
  logic             tvalid;
  logic             tnext;

  modport master (output tdata, output tfirst, output tlast, output tvalid, input tnext);
  modport slave  (input tdata, input tfirst, input tlast, input tvalid, output tnext);
endinterface

// File: rtl/axis_width_conv_gearbox.sv
// N-bit to M-bit stream gearbox with frame alignment.
// Bits are held MSB-first in a left-aligned CAP-bit buffer, where the oldest bit
// is at the top. Every bit carries a first flag and a last flag. Each frame is
// padded with zeros so that it starts on an output word boundary.
module axis_width_conv_gearbox #(
  parameter int N   = 8,
  parameter int M   = 12,
  parameter int CAP = 2 * (N + M)
) (
  input  logic                            clk,
  input  logic                            rst,
  axis_width_conv_gearbox_if.slave        s_axis,
  axis_width_conv_gearbox_if.master       m_axis,
  output logic [15:0]                     bit_count
);

  localparam int CW  = $clog2(CAP + 1);
  localparam int CKW = N + 2 * M;

  localparam logic [CW-1:0]  N_C    = CW'(N);
  localparam logic [CW-1:0]  NM1_C  = CW'(N - 1);
  localparam logic [CW-1:0]  M_C    = CW'(M);
  localparam logic [CW-1:0]  CAP_C  = CW'(CAP);
  // N mod M is folded at elaboration, so the run-time modulo needs only one compare.
  localparam logic [CW-1:0]  NMOD_C = CW'(N % M);
  localparam logic [CKW-1:0] MSB_ONE = {1'b1, {(CKW - 1){1'b0}}};

  if (CAP < N + 2 * M) begin : g_cap_check
    $error("axis_width_conv_gearbox: CAP must be at least N+2*M");
  end
  if (CW > 16) begin : g_width_check
    $error("axis_width_conv_gearbox: $clog2(CAP+1) must not exceed 16");
  end

  logic [CAP-1:0] buf_data, buf_first, buf_last;
  logic [CW-1:0]  cnt, offs;

  logic [CW-1:0]  pre, o_eff, sum, rem, post, w, offs_nxt, base;
  logic [CKW-1:0] chunk_data, chunk_first, chunk_last;
  logic [CAP-1:0] ext_data, ext_first, ext_last;
  logic [CAP-1:0] kept_data, kept_first, kept_last;
  logic           accept, pop, m_valid;

  // Size of the incoming write and the frame offset it leaves behind.
  always_comb begin
    pre      = (s_axis.tfirst && (offs != '0)) ? (M_C - offs) : '0;
    o_eff    = (pre != '0) ? '0 : offs;
    sum      = o_eff + NMOD_C;
    rem      = (sum >= M_C) ? (sum - M_C) : sum;
    post     = (s_axis.tlast && (rem != '0)) ? (M_C - rem) : '0;
    w        = pre + N_C + post;
    offs_nxt = s_axis.tlast ? '0 : rem;
  end

  // Build the write chunk left-aligned with its pre-padding. Post-padding is the zero tail.
  always_comb begin
    chunk_data  = {s_axis.tdata, {(2 * M){1'b0}}} >> pre;
    chunk_first = s_axis.tfirst ? (MSB_ONE >> pre) : '0;
    chunk_last  = s_axis.tlast ? (MSB_ONE >> (pre + NM1_C)) : '0;
    ext_data    = '0;
    ext_first   = '0;
    ext_last    = '0;
    ext_data[CAP-1 -: CKW]  = chunk_data;
    ext_first[CAP-1 -: CKW] = chunk_first;
    ext_last[CAP-1 -: CKW]  = chunk_last;
  end

  // Handshake decisions. Accept looks only at the registered occupancy.
  always_comb begin
    m_valid    = (cnt >= M_C);
    accept     = rst && s_axis.tvalid && ((CAP_C - cnt) >= w);
    pop        = m_axis.tnext && m_valid;
    base       = pop ? (cnt - M_C) : cnt;
    kept_data  = pop ? (buf_data << M) : buf_data;
    kept_first = pop ? (buf_first << M) : buf_first;
    kept_last  = pop ? (buf_last << M) : buf_last;
  end

  assign s_axis.tnext  = accept;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = buf_data[CAP-1 -: M];
  assign m_axis.tfirst = buf_first[CAP-1];
  assign m_axis.tlast  = |buf_last[CAP-1 -: M];
  assign bit_count     = 16'(cnt);

  // Buffer, occupancy and frame offset update. Bits below cnt are always kept zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_data  <= '0;
      buf_first <= '0;
      buf_last  <= '0;
      cnt       <= '0;
      offs      <= '0;
    end else if (accept) begin
      buf_data  <= kept_data | (ext_data >> base);
      buf_first <= kept_first | (ext_first >> base);
      buf_last  <= kept_last | (ext_last >> base);
      cnt       <= base + w;
      offs      <= offs_nxt;
    end else begin
      buf_data  <= kept_data;
      buf_first <= kept_first;
      buf_last  <= kept_last;
      cnt       <= base;
    end
  end

endmodule

// File: tb/tb_axis_width_conv_gearbox.sv
// Directed bench for the gearbox. It uses three instances:
//   a: N=12, M=8, default CAP
//   b: N=4,  M=12, CAP=32
//   c: N=8,  M=12, CAP=32
module tb_axis_width_conv_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic [15:0] bc_a, bc_b, bc_c;
  int          checks = 0;
  int          failures = 0;

  axis_width_conv_gearbox_if #(.WIDTH(12)) a_s ();
  axis_width_conv_gearbox_if #(.WIDTH(8))  a_m ();
  axis_width_conv_gearbox_if #(.WIDTH(4))  b_s ();
  axis_width_conv_gearbox_if #(.WIDTH(12)) b_m ();
  axis_width_conv_gearbox_if #(.WIDTH(8))  c_s ();
  axis_width_conv_gearbox_if #(.WIDTH(12)) c_m ();

  axis_width_conv_gearbox #(.N(12), .M(8)) dut_a (
    .clk(clk), .rst(rst_a), .s_axis(a_s), .m_axis(a_m), .bit_count(bc_a)
  );
  axis_width_conv_gearbox #(.N(4), .M(12), .CAP(32)) dut_b (
    .clk(clk), .rst(rst_b), .s_axis(b_s), .m_axis(b_m), .bit_count(bc_b)
  );
  axis_width_conv_gearbox #(.N(8), .M(12), .CAP(32)) dut_c (
    .clk(clk), .rst(rst_c), .s_axis(c_s), .m_axis(c_m), .bit_count(bc_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [11:0] d, input logic f, input logic l, input logic v);
    a_s.tdata = d; a_s.tfirst = f; a_s.tlast = l; a_s.tvalid = v;
  endtask

  task automatic drive_b(input logic [3:0] d, input logic f, input logic l, input logic v);
    b_s.tdata = d; b_s.tfirst = f; b_s.tlast = l; b_s.tvalid = v;
  endtask

  task automatic drive_c(input logic [7:0] d, input logic f, input logic l, input logic v);
    c_s.tdata = d; c_s.tfirst = f; c_s.tlast = l; c_s.tvalid = v;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    drive_a(12'h0, 1'b0, 1'b0, 1'b0);
    drive_b(4'h7, 1'b1, 1'b1, 1'b1);
    drive_c(8'h0, 1'b0, 1'b0, 1'b0);
    a_m.tnext = 1'b0; b_m.tnext = 1'b0; c_m.tnext = 1'b0;
    step();
    step();

    // reset state
    chk("rst_a_valid", 32'(a_m.tvalid), 32'h0);
    chk("rst_a_data",  32'(a_m.tdata),  32'h0);
    chk("rst_a_count", 32'(bc_a),       32'h0);
    chk("rst_b_tnext_forced", 32'(b_s.tnext), 32'h0);
    chk("rst_b_count", 32'(bc_b),       32'h0);
    chk("rst_c_flags", 32'({c_m.tfirst, c_m.tlast, c_m.tvalid}), 32'h0);

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    drive_b(4'h0, 1'b0, 1'b0, 1'b0);
    #1;

    // single-word frame 0xABC, N=12 M=8
    drive_a(12'hABC, 1'b1, 1'b1, 1'b1);
    #1;
    chk("t1_accept", 32'(a_s.tnext), 32'h1);
    step();
    drive_a(12'h0, 1'b0, 1'b0, 1'b0);
    chk("t1_count16", 32'(bc_a), 32'd16);
    chk("t1_w0", 32'({a_m.tvalid, a_m.tfirst, a_m.tlast, a_m.tdata}), 32'({1'b1, 1'b1, 1'b0, 8'hAB}));
    a_m.tnext = 1'b1;
    step();
    chk("t1_w1", 32'({a_m.tvalid, a_m.tfirst, a_m.tlast, a_m.tdata}), 32'({1'b1, 1'b0, 1'b1, 8'hC0}));
    chk("t1_count8", 32'(bc_a), 32'd8);
    step();
    chk("t1_empty", 32'({a_m.tvalid, bc_a}), 32'h0);

    // two-word frame, consumer always ready (tnext ignored while not valid)
    drive_a(12'hABC, 1'b1, 1'b0, 1'b1);
    step();
    chk("t2_count12", 32'(bc_a), 32'd12);
    chk("t2_w0", 32'({a_m.tvalid, a_m.tfirst, a_m.tlast, a_m.tdata}), 32'({1'b1, 1'b1, 1'b0, 8'hAB}));
    drive_a(12'hDEF, 1'b0, 1'b1, 1'b1);
    step();
    drive_a(12'h0, 1'b0, 1'b0, 1'b0);
    chk("t2_count16", 32'(bc_a), 32'd16);
    chk("t2_w1", 32'({a_m.tvalid, a_m.tfirst, a_m.tlast, a_m.tdata}), 32'({1'b1, 1'b0, 1'b0, 8'hCD}));
    step();
    chk("t2_w2", 32'({a_m.tvalid, a_m.tfirst, a_m.tlast, a_m.tdata}), 32'({1'b1, 1'b0, 1'b1, 8'hEF}));
    step();
    a_m.tnext = 1'b0;
    chk("t2_drained", 32'({a_m.tvalid, bc_a}), 32'h0);

    // N=4 M=12: exact-fit frame then padded frame
    drive_b(4'hA, 1'b1, 1'b0, 1'b1); step();
    drive_b(4'hB, 1'b0, 1'b0, 1'b1); step();
    chk("t3_partial_invalid", 32'({b_m.tvalid, b_m.tdata}), 32'({1'b0, 12'hAB0}));
    drive_b(4'hC, 1'b0, 1'b1, 1'b1); step();
    drive_b(4'h1, 1'b1, 1'b0, 1'b0);
    chk("t3_w0", 32'({b_m.tvalid, b_m.tfirst, b_m.tlast, b_m.tdata}), 32'({1'b1, 1'b1, 1'b1, 12'hABC}));
    chk("t3_count12", 32'(bc_b), 32'd12);
    b_m.tnext = 1'b1; step(); b_m.tnext = 1'b0;
    chk("t3_count0", 32'(bc_b), 32'd0);
    drive_b(4'h1, 1'b1, 1'b0, 1'b1); step();
    drive_b(4'h2, 1'b0, 1'b1, 1'b1); step();
    drive_b(4'h0, 1'b0, 1'b0, 1'b0);
    chk("t3_w1", 32'({b_m.tvalid, b_m.tfirst, b_m.tlast, b_m.tdata}), 32'({1'b1, 1'b1, 1'b1, 12'h120}));
    b_m.tnext = 1'b1; step(); b_m.tnext = 1'b0;

    // N=4 M=12: unterminated frame closed by the next tfirst
    drive_b(4'hA, 1'b1, 1'b0, 1'b1); step();
    drive_b(4'hB, 1'b0, 1'b0, 1'b1); step();
    drive_b(4'h5, 1'b1, 1'b1, 1'b1); step();
    drive_b(4'h0, 1'b0, 1'b0, 1'b0);
    chk("t4_count24", 32'(bc_b), 32'd24);
    chk("t4_w0", 32'({b_m.tvalid, b_m.tfirst, b_m.tlast, b_m.tdata}), 32'({1'b1, 1'b1, 1'b0, 12'hAB0}));
    b_m.tnext = 1'b1; step(); b_m.tnext = 1'b0;
    chk("t4_w1", 32'({b_m.tvalid, b_m.tfirst, b_m.tlast, b_m.tdata}), 32'({1'b1, 1'b1, 1'b1, 12'h500}));
    b_m.tnext = 1'b1; step(); b_m.tnext = 1'b0;
    chk("t4_count0", 32'(bc_b), 32'd0);

    // N=8 M=12 CAP=32: fill to the full boundary, then free one word
    drive_c(8'h11, 1'b0, 1'b0, 1'b1); step();
    drive_c(8'h22, 1'b0, 1'b0, 1'b1); step();
    drive_c(8'h33, 1'b0, 1'b0, 1'b1); step();
    drive_c(8'h44, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t5_exact_fit_accept", 32'(c_s.tnext), 32'h1);
    step();
    drive_c(8'h55, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t5_full_count", 32'(bc_c), 32'd32);
    chk("t5_full_hold", 32'(c_s.tnext), 32'h0);
    chk("t5_head", 32'({c_m.tvalid, c_m.tdata}), 32'({1'b1, 12'h112}));
    step();
    chk("t5_still_full", 32'({c_s.tnext, bc_c}), 32'd32);
    c_m.tnext = 1'b1;
    #1;
    chk("t5_no_ready_credit", 32'(c_s.tnext), 32'h0);
    step();
    c_m.tnext = 1'b0;
    #1;
    chk("t5_after_pop", 32'(bc_c), 32'd20);
    chk("t5_accept_after_pop", 32'(c_s.tnext), 32'h1);
    step();
    drive_c(8'h66, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t5_count28", 32'(bc_c), 32'd28);
    chk("t5_hold28", 32'(c_s.tnext), 32'h0);
    chk("t5_head2", 32'(c_m.tdata), 32'h233);
    drive_c(8'h0, 1'b0, 1'b0, 1'b0);

    // mid-frame reset on instance b with 20 bits buffered
    drive_b(4'h1, 1'b1, 1'b0, 1'b1); step();
    drive_b(4'h2, 1'b0, 1'b0, 1'b1); step();
    drive_b(4'h3, 1'b0, 1'b0, 1'b1); step();
    drive_b(4'h4, 1'b0, 1'b0, 1'b1); step();
    drive_b(4'h5, 1'b0, 1'b0, 1'b1); step();
    drive_b(4'h6, 1'b0, 1'b0, 1'b1);
    rst_b = 1'b0;
    #1;
    chk("t6_pre_count20", 32'(bc_b), 32'd20);
    chk("t6_pre_head", 32'({b_m.tvalid, b_m.tfirst, b_m.tdata}), 32'({1'b1, 1'b1, 12'h123}));
    chk("t6_tnext_forced", 32'(b_s.tnext), 32'h0);
    step();
    rst_b = 1'b1;
    drive_b(4'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t6_cleared", 32'({b_m.tvalid, b_m.tfirst, b_m.tlast, b_m.tdata, bc_b}), 32'h0);
    drive_b(4'h9, 1'b1, 1'b1, 1'b1);
    #1;
    chk("t6_accept_after_rst", 32'(b_s.tnext), 32'h1);
    step();
    drive_b(4'h0, 1'b0, 1'b0, 1'b0);
    chk("t6_new_frame", 32'({b_m.tvalid, b_m.tfirst, b_m.tlast, b_m.tdata}), 32'({1'b1, 1'b1, 1'b1, 12'h900}));
    chk("t6_count12", 32'(bc_b), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_width_conv_gearbox.md
# axis_width_conv_gearbox

Generic AXI-Stream-style bit gearbox that converts an N-bit input stream to an M-bit output stream for any N and M: wide-to-narrow, narrow-to-wide and non-integer ratios. It uses the same `tnext`/`tvalid`/`tfirst` handshake as the existing width converters. It adds frame awareness: `tlast` tracking with zero-padding, so every frame starts on an output word boundary. It sits between stream producers and consumers whose word widths do not divide one another.

## Interface
- `N`, 8, input word width in bits (≥1)
- `M`, 12, output word width in bits (≥1)
- `CAP`, 2*(N+M), bit-buffer capacity
  - Elaboration error if CAP < N+2*M.
  - Elaboration error if $clog2(CAP+1) > 16.
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `s_axis_tnext`  out  1  input accept strobe, combinational: `s_axis_tvalid` && space available
- `s_axis_tdata`  in  N  input word; MSB is the first bit transmitted
- `s_axis_tfirst`  in  1  word is the first of a frame
- `s_axis_tlast`  in  1  word is the last of a frame
- `s_axis_tvalid`  in  1  input word present
- `m_axis_tnext`  in  1  consumer takes the current output word when `m_axis_tvalid`
- `m_axis_tdata`  out  M  output word; MSB is the oldest bit
- `m_axis_tfirst`  out  1  output word begins a frame
- `m_axis_tlast`  out  1  output word contains the last bit of a frame
- `m_axis_tvalid`  out  1  at least M bits are buffered
- `bit_count`  out  16  current buffer occupancy in bits, zero-extended

## Operation
- **Buffer:** a CAP-bit FIFO in bit order. Each stored bit carries a first flag and a last flag. The occupancy register is `cnt`.
- **Frame offset register `offs`:** range 0..M-1. Holds the number of bits of the current frame already written, modulo M.
- **Bits written per accepted word,** in this order:
  - `pre` zeros: `pre` = (M-offs) mod M when `s_axis_tfirst`=1, else 0. This implicitly closes an unterminated previous frame. No `tlast` is generated for that closed frame.
  - The N data bits, MSB first. The first flag is set on the first data bit when `s_axis_tfirst`=1.
  - `post` zeros: `post` = (M-((o'+N) mod M)) mod M when `s_axis_tlast`=1, else 0, where o' = 0 if `pre`≠0 else `offs`. The last flag is set on the final data bit.
  - W = `pre`+N+`post` ≤ N+2M-2.
- **Accept:** `s_axis_tnext` = `s_axis_tvalid` && (CAP-`cnt` ≥ W). The decision uses the registered `cnt` only; there is no credit for a read in the same cycle.
- **`offs` update on accept:**
  - `tlast`=1: `offs` ← 0.
  - Otherwise: `offs` ← (o'+N) mod M.
- **Output word:** the oldest M bits.
  - `m_axis_tfirst` = first flag of the oldest bit.
  - `m_axis_tlast` = OR of the last flags across the M bits.
  - When `m_axis_tvalid`=0, `m_axis_tdata` shows the buffered bits left-aligned with zeros below. The consumer must ignore it.
- **Read:** `m_axis_tnext` && `m_axis_tvalid` pops M bits. `m_axis_tnext` while not valid is ignored.
- **Simultaneous accept and pop:** `cnt` ← `cnt` + W − M.
- **Input flag ambiguity:** `tfirst` and `tlast` may both be 1 on the same word (a single-word frame).
- **Reset** (`rst`=0 at an edge), valid mid-frame:
  - Buffer, flags, `cnt` and `offs` are cleared.
  - All in-flight bits are discarded.
  - Inputs during reset cycles are not accepted: `s_axis_tnext` is forced 0 while `rst`=0.

## Timing
- **Output values after reset:**
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tfirst`=0, `m_axis_tlast`=0, `bit_count`=0.
  - `s_axis_tnext` follows `s_axis_tvalid` from the first cycle with `rst`=1.
- **Latency:** a word accepted at edge k appears in `cnt` and `bit_count` after edge k. `m_axis_tvalid` rises in cycle k+1 if `cnt` ≥ M. There is no combinational path from `s_axis_tdata` to `m_axis_tdata`.
- **Ready path:** `m_axis_tnext` does not combinationally affect `s_axis_tnext`. A pop frees space visible to the accept logic in the next cycle.
- **Full boundary:** with CAP-`cnt` < W, the word is held; `s_axis_tnext`=0. When CAP-`cnt` = W exactly, the word is accepted.
- **Empty boundary:** with 0 < `cnt` < M and no `tlast` pending, `m_axis_tvalid` stays 0 indefinitely. Flushing requires `tlast` or the `tfirst` of the next frame.
- **Width rules:** `cnt` and W use $clog2(CAP+1) bits. All modulo-M arithmetic is performed without a divider (M is constant; iterative subtraction over ≤3 compares).

## Test plan
- N=12, M=8. One word 0xABC with tfirst=tlast=1. Expected:
  - `bit_count`=16 next cycle.
  - Outputs 0xAB (tfirst=1, tlast=0), then 0xC0 (tfirst=0, tlast=1).
- N=12, M=8. 0xABC (tfirst), then 0xDEF (tlast), back-to-back with `m_axis_tnext`=1. Expected:
  - Outputs 0xAB (tfirst), 0xCD, 0xEF (tlast).
  - No padding; `bit_count` returns to 0.
- N=4, M=12. Frame 1 is 0xA, 0xB, 0xC (tlast on 0xC). Frame 2 is 0x1 (tfirst), 0x2 (tlast). Expected outputs:
  - 0xABC (tfirst, tlast).
  - 0x120 (tfirst, tlast).
- N=4, M=12. 0xA (tfirst), 0xB with no tlast, then 0x5 (tfirst, tlast). Expected outputs:
  - 0xAB0 (tfirst, tlast=0), from the implicit close.
  - 0x500 (tfirst, tlast).
- N=8, M=12, CAP=32. Hold `m_axis_tnext`=0 and drive `s_axis_tvalid`=1 continuously. Expected:
  - 4 words accepted; `bit_count`=32; `s_axis_tnext`=0 thereafter.
  - One pop gives `bit_count`=20. A word is accepted in the following cycle, giving `bit_count`=28.
- Assert `rst`=0 for one cycle mid-frame with `bit_count`=20. Expected:
  - Next cycle: all outputs 0 and `bit_count`=0.
  - A new tfirst+tlast word produces correctly padded output with tfirst set.
